// File: rtl/sysid_probe_pkg.sv
// ---------------------------------------------------------------------------
// sysid_probe_pkg : shared states and constants for the sysid probe master
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sysid_probe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_LAT  = 3'd2,
    ST_NEXT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_TIMESTAMP = 32'd1363693817;

  // Stall counter width: wide enough for TIMEOUT_CYCLES, clamped to 8..16 bits.
  function automatic int tmo_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    if (w < 8)  w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sysid_probe_master.sv
// ---------------------------------------------------------------------------
// sysid_probe_master : Avalon-MM reader that checks the sysid ID/timestamp words
// Optional stall timeout when SYSID_PROBE_TIMEOUT_EN is defined.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sysid_probe_master
  import sysid_probe_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
  parameter int          READ_LATENCY       = 0,
  parameter bit          AUTO_START         = 1'b1,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int LAT_LAST_I = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
  localparam int LAT_PRE_I  = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
  localparam logic [1:0] LAT_LAST = 2'(LAT_LAST_I);
  localparam logic [1:0] LAT_PRE  = 2'(LAT_PRE_I);

  state_t      state_q, state_d;
  logic        auto_q, auto_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        id_match_q, id_match_d;
  logic        ts_match_q, ts_match_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  logic        capture;

`ifdef SYSID_PROBE_TIMEOUT_EN
  localparam int TMO_W = tmo_width(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d    = state_q;
    auto_d     = auto_q;
    read_d     = read_q;
    addr_d     = addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    id_match_d = id_match_q;
    ts_match_d = ts_match_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    lat_cnt_d  = lat_cnt_q;
    capture    = 1'b0;
`ifdef SYSID_PROBE_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    timeout_d  = timeout_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start || auto_q) begin
          auto_d     = 1'b0;
          state_d    = ST_REQ;
          read_d     = 1'b1;
          addr_d     = SYSID_ADDR_ID;
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          id_match_d = 1'b0;
          ts_match_d = 1'b0;
          id_value_d = '0;
          ts_value_d = '0;
`ifdef SYSID_PROBE_TIMEOUT_EN
          tmo_cnt_d  = '0;
          timeout_d  = 1'b0;
`endif
        end
      end

      ST_REQ: begin
        if (!avm_waitrequest) begin
          lat_cnt_d = 2'd0;
`ifdef SYSID_PROBE_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
          if (READ_LATENCY == 0) begin
            capture = 1'b1;
          end else if (READ_LATENCY == 1 && addr_q == SYSID_ADDR_ID) begin
            read_d  = 1'b0;
            state_d = ST_NEXT;
          end else begin
            read_d  = 1'b0;
            state_d = ST_LAT;
          end
        end
`ifdef SYSID_PROBE_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          read_d    = 1'b0;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end

      // The ID read spends its final latency cycle in NEXT so the capture
      // edge can relaunch the timestamp read without an idle cycle.
      ST_LAT: begin
        lat_cnt_d = lat_cnt_q + 2'd1;
        if (addr_q == SYSID_ADDR_TS && lat_cnt_q == LAT_LAST) begin
          capture = 1'b1;
        end else if (addr_q == SYSID_ADDR_ID && lat_cnt_q == LAT_PRE) begin
          state_d = ST_NEXT;
        end
      end

      ST_NEXT: capture = 1'b1;

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      if (addr_q == SYSID_ADDR_ID) begin
        id_value_d = avm_readdata;
        id_match_d = (avm_readdata == EXPECTED_ID);
        addr_d     = SYSID_ADDR_TS;
        read_d     = 1'b1;
        state_d    = ST_REQ;
      end else begin
        ts_value_d = avm_readdata;
        ts_match_d = (avm_readdata == EXPECTED_TIMESTAMP);
        pass_d     = id_match_q & (avm_readdata == EXPECTED_TIMESTAMP);
        read_d     = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        state_d    = ST_DONE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      auto_q     <= AUTO_START;
      read_q     <= 1'b0;
      addr_q     <= SYSID_ADDR_ID;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      id_match_q <= 1'b0;
      ts_match_q <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
      lat_cnt_q  <= 2'd0;
`ifdef SYSID_PROBE_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      auto_q     <= auto_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      id_match_q <= id_match_d;
      ts_match_q <= ts_match_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      lat_cnt_q  <= lat_cnt_d;
`ifdef SYSID_PROBE_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign avm_read    = read_q;
  assign avm_address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_match    = id_match_q;
  assign ts_match    = ts_match_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
`ifdef SYSID_PROBE_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sysid_probe_master.sv
// Directed bench: dut0 (latency 0, auto start, timeout 8) and dut2 (latency 2, stalling slave).
`default_nettype none

module tb_sysid_probe_master;

  localparam logic [31:0] TS = 32'd1363693817;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic rst_n;

  logic        start0, rd0, addr0, w0, busy0, done0, pass0, idm0, tsm0, tmo0;
  logic [31:0] rdata0, idv0, tsv0;
  logic [31:0] id_word0, ts_word0;
  logic        stuck0;

  logic        start2, rd2, addr2, w2, busy2, done2, pass2, idm2, tsm2, tmo2;
  logic [31:0] rdata2, idv2, tsv2;

  assign w0     = stuck0;
  assign rdata0 = addr0 ? ts_word0 : id_word0;

  // Latency-2 slave: three stall cycles per command, data valid only in the due cycle.
  int   stall2 = 0;
  logic p1 = 1'b0, p2 = 1'b0, a1 = 1'b0, a2 = 1'b0;
  assign w2     = rd2 && (stall2 < 3);
  assign rdata2 = p2 ? (a2 ? TS : 32'd0) : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (rd2 && w2)  stall2 <= stall2 + 1;
    else if (rd2)   stall2 <= 0;
    p1 <= rd2 && !w2;
    a1 <= addr2;
    p2 <= p1;
    a2 <= a1;
  end

  sysid_probe_master #(
    .EXPECTED_ID(32'd0), .EXPECTED_TIMESTAMP(TS), .READ_LATENCY(0),
    .AUTO_START(1'b1), .TIMEOUT_CYCLES(8)
  ) dut0 (
    .clock(clk), .reset_n(rst_n), .start(start0),
    .avm_address(addr0), .avm_read(rd0), .avm_waitrequest(w0), .avm_readdata(rdata0),
    .busy(busy0), .done(done0), .pass(pass0), .id_match(idm0), .ts_match(tsm0),
    .timeout(tmo0), .id_value(idv0), .ts_value(tsv0)
  );

  sysid_probe_master #(
    .EXPECTED_ID(32'd0), .EXPECTED_TIMESTAMP(TS), .READ_LATENCY(2),
    .AUTO_START(1'b0), .TIMEOUT_CYCLES(255)
  ) dut2 (
    .clock(clk), .reset_n(rst_n), .start(start2),
    .avm_address(addr2), .avm_read(rd2), .avm_waitrequest(w2), .avm_readdata(rdata2),
    .busy(busy2), .done(done2), .pass(pass2), .id_match(idm2), .ts_match(tsm2),
    .timeout(tmo2), .id_value(idv2), .ts_value(tsv2)
  );

  task automatic test_reset();
    rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0; stuck0 = 1'b0;
    id_word0 = 32'd0; ts_word0 = TS;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd0, addr0, busy0, done0, pass0, idm0, tsm0, tmo0, idv0, tsv0} !== 72'd0) begin
      errors++; $display("FAIL reset_dut0 got %h want 0", {rd0, addr0, busy0, done0, pass0, idm0, tsm0, tmo0, idv0, tsv0});
    end
    checks++;
    if ({rd2, addr2, busy2, done2, pass2, idm2, tsm2, tmo2, idv2, tsv2} !== 72'd0) begin
      errors++; $display("FAIL reset_dut2 got %h want 0", {rd2, addr2, busy2, done2, pass2, idm2, tsm2, tmo2, idv2, tsv2});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_auto_start();
    int n = 0;
    while (done0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (done0 !== 1'b1 || pass0 !== 1'b1 || tsv0 !== TS) begin
      errors++; $display("FAIL auto_start done=%b pass=%b ts=%h want 1 1 %h", done0, pass0, tsv0, TS);
    end
    checks++;
    if (busy2 !== 1'b0) begin errors++; $display("FAIL auto_off busy2=%b want 0", busy2); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int ks;
    @(negedge clk); start0 = 1'b1; @(negedge clk); start0 = 1'b0; ks = cyc;
    checks++;
    if (rd0 !== 1'b1 || addr0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++; $display("FAIL basic_rd_id rd=%b addr=%b busy=%b want 1 0 1", rd0, addr0, busy0);
    end
    @(negedge clk);
    checks++;
    if (rd0 !== 1'b1 || addr0 !== 1'b1 || done0 !== 1'b0) begin
      errors++; $display("FAIL basic_rd_ts rd=%b addr=%b done=%b want 1 1 0", rd0, addr0, done0);
    end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b1 || (cyc - ks) !== 2 || rd0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL basic_done done=%b dt=%0d rd=%b busy=%b want 1 2 0 0", done0, cyc - ks, rd0, busy0);
    end
    checks++;
    if (pass0 !== 1'b1 || idm0 !== 1'b1 || tsm0 !== 1'b1 || idv0 !== 32'd0 || tsv0 !== TS) begin
      errors++; $display("FAIL basic_result pass=%b idm=%b tsm=%b id=%h ts=%h", pass0, idm0, tsm0, idv0, tsv0);
    end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || pass0 !== 1'b1) begin
      errors++; $display("FAIL basic_hold done=%b pass=%b want 0 1", done0, pass0);
    end
  endtask

  task automatic test_id_mismatch();
    int n = 0;
    id_word0 = 32'h0000_0001;
    @(negedge clk); start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    while (done0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (done0 !== 1'b1 || idm0 !== 1'b0 || tsm0 !== 1'b1 || pass0 !== 1'b0 || idv0 !== 32'd1) begin
      errors++; $display("FAIL id_mismatch done=%b idm=%b tsm=%b pass=%b id=%h want 1 0 1 0 1", done0, idm0, tsm0, pass0, idv0);
    end
    id_word0 = 32'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency();
    int ks; int n = 0; int bad = 0;
    logic prev_stall = 1'b0; logic prev_addr = 1'b0;
    @(negedge clk); start2 = 1'b1; @(negedge clk); start2 = 1'b0; ks = cyc;
    while (done2 !== 1'b1 && n < 40) begin
      if (prev_stall && rd2 && addr2 !== prev_addr) bad++;
      prev_stall = rd2 && w2; prev_addr = addr2;
      @(negedge clk); n++;
    end
    checks++;
    if (done2 !== 1'b1 || (cyc - ks) !== 12) begin
      errors++; $display("FAIL latency_timing done=%b dt=%0d want 1 12", done2, cyc - ks);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL latency_addr_stable changes=%0d want 0", bad); end
    checks++;
    if (pass2 !== 1'b1 || idv2 !== 32'd0 || tsv2 !== TS) begin
      errors++; $display("FAIL latency_result pass=%b id=%h ts=%h want 1 0 %h", pass2, idv2, tsv2, TS);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_restart_ignore();
    int dones = 0; int n = 0;
    @(negedge clk); start0 = 1'b1; @(negedge clk); start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    if (done0 === 1'b1) dones++;
    repeat (12) begin @(negedge clk); if (done0 === 1'b1) dones++; end
    checks++;
    if (dones !== 1 || pass0 !== 1'b1) begin
      errors++; $display("FAIL restart_ignored dones=%0d pass=%b want 1 1", dones, pass0);
    end
    @(negedge clk); start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    checks++;
    if (pass0 !== 1'b0 || tsm0 !== 1'b0 || tsv0 !== 32'd0 || busy0 !== 1'b1) begin
      errors++; $display("FAIL restart_clear pass=%b tsm=%b ts=%h busy=%b want 0 0 0 1", pass0, tsm0, tsv0, busy0);
    end
    while (done0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (done0 !== 1'b1 || pass0 !== 1'b1 || tsv0 !== TS) begin
      errors++; $display("FAIL restart_repeat done=%b pass=%b ts=%h", done0, pass0, tsv0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int ks; int n = 0;
    stuck0 = 1'b1;
    @(negedge clk); start0 = 1'b1; @(negedge clk); start0 = 1'b0; ks = cyc;
`ifdef SYSID_PROBE_TIMEOUT_EN
    while (done0 !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    checks++;
    if (done0 !== 1'b1 || (cyc - ks) !== 8) begin
      errors++; $display("FAIL timeout_timing done=%b dt=%0d want 1 8", done0, cyc - ks);
    end
    checks++;
    if (rd0 !== 1'b0 || tmo0 !== 1'b1 || pass0 !== 1'b0 || idv0 !== 32'd0 || idm0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL timeout_flags rd=%b tmo=%b pass=%b id=%h idm=%b busy=%b", rd0, tmo0, pass0, idv0, idm0, busy0);
    end
`else
    while (done0 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b1 || rd0 !== 1'b1 || tmo0 !== 1'b0 || addr0 !== 1'b0) begin
      errors++; $display("FAIL stall_forever done=%b busy=%b rd=%b tmo=%b addr=%b after %0d", done0, busy0, rd0, tmo0, addr0, cyc - ks);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int n = 0;
    @(negedge clk); start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy0 !== 1'b1 || rd0 !== 1'b1) begin
      errors++; $display("FAIL mid_stalled busy=%b rd=%b want 1 1", busy0, rd0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd0, addr0, busy0, done0, pass0, idm0, tsm0, tmo0, idv0, tsv0} !== 72'd0) begin
      errors++; $display("FAIL mid_reset got %h want 0", {rd0, addr0, busy0, done0, pass0, idm0, tsm0, tmo0, idv0, tsv0});
    end
    stuck0 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    while (rd0 !== 1'b1 && n < 2) begin @(negedge clk); n++; end
    checks++;
    if (rd0 !== 1'b1 || addr0 !== 1'b0) begin
      errors++; $display("FAIL mid_restart rd=%b addr=%b after %0d want 1 0", rd0, addr0, n);
    end
    n = 0;
    while (done0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (done0 !== 1'b1 || pass0 !== 1'b1 || tmo0 !== 1'b0) begin
      errors++; $display("FAIL mid_rerun done=%b pass=%b tmo=%b want 1 1 0", done0, pass0, tmo0);
    end
  endtask

  initial begin
    test_reset();
    test_auto_start();
    test_basic();
    test_id_mismatch();
    test_latency();
    test_restart_ignore();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
